// File: rtl/i2c_slave_regfile_if.sv
// i2c_slave_regfile_if: pad-side and system-side signals of the I2C slave
// register file, bundled as one port.
//   slave  modport : used by i2c_slave_regfile
//   master modport : used by whatever drives the pads and the host read port
// Signals:
//   scl_i, sda_i  I2C pad inputs (asynchronous)
//   sda_oe        1 = pull SDA low (open drain)
//   wr_stb/wr_addr/wr_data  one-cycle notification of an I2C register write
//   host_addr/host_rdata    system-side combinational read port
//   busy          transaction in progress
interface i2c_slave_regfile_if #(parameter int PTR_W = 4);
  logic             scl_i;
  logic             sda_i;
  logic             sda_oe;
  logic             wr_stb;
  logic [PTR_W-1:0] wr_addr;
  logic [7:0]       wr_data;
  logic [PTR_W-1:0] host_addr;
  logic [7:0]       host_rdata;
  logic             busy;

  modport slave (
    input  scl_i, sda_i, host_addr,
    output sda_oe, wr_stb, wr_addr, wr_data, host_rdata, busy
  );

  modport master (
    output scl_i, sda_i, host_addr,
    input  sda_oe, wr_stb, wr_addr, wr_data, host_rdata, busy
  );
endinterface

// File: rtl/i2c_slave_regfile.sv
// i2c_slave_regfile: I2C slave with an internal byte register file and an
// auto-incrementing register pointer.
//   clk, rst : system clock (>= 10x SCL), synchronous active-high reset
//   bus      : i2c_slave_regfile_if.slave (pads, write strobe, host read port)
// Transaction format: S addr+W ptr data... P  /  S addr+R data... P
// (repeated START allowed anywhere). SCL/SDA are oversampled on clk.
// Optional feature: define GEN_CALL_EN to ACK the general-call address
// (7'h00 + W); the following bytes are then written from the current
// pointer without a pointer byte. Without it, 7'h00 is a plain mismatch.
module i2c_slave_regfile #(
  parameter logic [6:0] SLAVE_ADDR = 7'h42,
  parameter int         NUM_REGS   = 16,
  parameter int         PTR_W      = 4,
  parameter logic [7:0] RST_VAL    = 8'h00
) (
  input logic                clk,
  input logic                rst,
  i2c_slave_regfile_if.slave bus
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK
  } state_t;

  state_t                   state, ack_nxt;
  logic [1:0]               scl_s, sda_s;
  logic                     scl_d, sda_d;
  logic                     scl, sda;
  logic                     scl_rise, scl_fall, start_det, stop_det;
  logic [3:0]               cnt;
  logic [7:0]               sh, rx_byte;
  logic [PTR_W-1:0]         ptr, ptr_inc;
  logic [NUM_REGS-1:0][7:0] regs;
  logic                     addr_hit, addr_gc;
  logic                     sda_oe_q, wr_stb_q, busy_q;
  logic [PTR_W-1:0]         wr_addr_q;
  logic [7:0]               wr_data_q;

  // 2-FF synchronisers plus one delay stage for edge detection. Reset to
  // the idle-bus level so no spurious edge is seen leaving reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_s <= 2'b11;
      sda_s <= 2'b11;
      scl_d <= 1'b1;
      sda_d <= 1'b1;
    end else begin
      scl_s <= {scl_s[0], bus.scl_i};
      sda_s <= {sda_s[0], bus.sda_i};
      scl_d <= scl_s[1];
      sda_d <= sda_s[1];
    end
  end

  assign scl       = scl_s[1];
  assign sda       = sda_s[1];
  assign scl_rise  = scl & ~scl_d;
  assign scl_fall  = ~scl & scl_d;
  assign start_det = scl & scl_d & sda_d & ~sda;
  assign stop_det  = scl & scl_d & ~sda_d & sda;

  // Byte as it stands once the current rising-edge bit is shifted in.
  assign rx_byte  = {sh[6:0], sda};
  assign ptr_inc  = ptr + PTR_W'(1);
  assign addr_hit = (rx_byte[7:1] == SLAVE_ADDR);
`ifdef GEN_CALL_EN
  assign addr_gc  = (rx_byte == 8'h00);
`else
  assign addr_gc  = 1'b0;
`endif

  assign bus.host_rdata = regs[bus.host_addr];
  assign bus.sda_oe     = sda_oe_q;
  assign bus.wr_stb     = wr_stb_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = wr_data_q;
  assign bus.busy       = busy_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ack_nxt   <= IDLE;
      cnt       <= '0;
      sh        <= '0;
      ptr       <= '0;
      regs      <= {NUM_REGS{RST_VAL}};
      sda_oe_q  <= 1'b0;
      wr_stb_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      wr_stb_q <= 1'b0;
      if (start_det) begin
        state    <= ADDR;
        cnt      <= '0;
        busy_q   <= 1'b1;
        sda_oe_q <= 1'b0;
      end else if (stop_det) begin
        state    <= IDLE;
        busy_q   <= 1'b0;
        sda_oe_q <= 1'b0;
      end else begin
        unique case (state)
          IDLE: ;
          // Master-driven bytes: sample on scl rise, decide on the 8th bit.
          ADDR, PTR, WDATA: begin
            if (scl_rise) begin
              sh  <= rx_byte;
              cnt <= cnt + 4'd1;
              if (cnt == 4'd7) begin
                if (state == ADDR) begin
                  if (addr_hit) begin
                    state   <= ADDR_ACK;
                    ack_nxt <= rx_byte[0] ? RDATA : PTR;
                  end else if (addr_gc) begin
                    state   <= ADDR_ACK;
                    ack_nxt <= WDATA;
                  end else begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                  end
                end else if (state == PTR) begin
                  ptr     <= rx_byte[PTR_W-1:0];
                  state   <= PTR_ACK;
                  ack_nxt <= WDATA;
                end else begin
                  regs[ptr] <= rx_byte;
                  wr_stb_q  <= 1'b1;
                  wr_addr_q <= ptr;
                  wr_data_q <= rx_byte;
                  ptr       <= ptr_inc;
                  state     <= WDATA_ACK;
                  ack_nxt   <= WDATA;
                end
              end
            end
          end
          // Slave ACK: first scl fall pulls SDA, second fall releases it.
          // sda_oe_q is never set on entry, so it doubles as the phase bit.
          ADDR_ACK, PTR_ACK, WDATA_ACK: begin
            if (scl_fall) begin
              if (!sda_oe_q) begin
                sda_oe_q <= 1'b1;
              end else begin
                state <= ack_nxt;
                cnt   <= '0;
                if (ack_nxt == RDATA) begin
                  // First read bit goes out on this same fall.
                  sh       <= regs[ptr];
                  sda_oe_q <= ~regs[ptr][7];
                end else begin
                  sda_oe_q <= 1'b0;
                end
              end
            end
          end
          // cnt counts bits the master has already sampled. cnt==0 on a
          // fall only happens after a master ACK reload.
          RDATA: begin
            if (scl_rise) begin
              cnt <= cnt + 4'd1;
            end else if (scl_fall) begin
              if (cnt == 4'd0) begin
                sda_oe_q <= ~sh[7];
              end else if (cnt == 4'd8) begin
                sda_oe_q <= 1'b0;
                state    <= RDATA_ACK;
              end else begin
                sh       <= {sh[6:0], 1'b0};
                sda_oe_q <= ~sh[6];
              end
            end
          end
          RDATA_ACK: begin
            if (scl_rise) begin
              if (!sda) begin
                ptr   <= ptr_inc;
                sh    <= regs[ptr_inc];
                cnt   <= '0;
                state <= RDATA;
              end else begin
                state  <= IDLE;
                busy_q <= 1'b0;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
